// File: rtl/sd_sector_arbiter_pkg.sv
// Shared types for the SD sector arbiter: FSM states and sector/byte widths.
// Latency: n/a (types only).
// Backpressure: n/a.
package sd_sector_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAITDONE
    } arb_state_t;

    localparam int SECTOR_BYTES = 512;
    localparam int SECTOR_AW    = $clog2(SECTOR_BYTES);

    typedef logic [31:0]          sector_t;
    typedef logic [SECTOR_AW-1:0] byte_addr_t;
    typedef logic [7:0]           byte_t;

endpackage

// File: rtl/sd_sector_arbiter_if.sv
// Link between the arbiter (master) and the single-sector SD reader (slave).
// Latency: wires only.
// Backpressure: none; the reader paces the link with rbusy/rdone.
interface sd_sector_arbiter_if;
    import sd_sector_arbiter_pkg::*;

    logic       rstart;
    sector_t    rsector_no;
    logic       rbusy;
    logic       rdone;
    logic       outreq;
    byte_addr_t outaddr;
    byte_t      outbyte;

    modport master (
        output rstart, rsector_no,
        input  rbusy, rdone, outreq, outaddr, outbyte
    );

    modport slave (
        input  rstart, rsector_no,
        output rbusy, rdone, outreq, outaddr, outbyte
    );

endinterface

// File: rtl/sd_sector_arbiter_rr_picker.sv
// Round-robin picker: first set request strictly after ptr, wrapping around.
// Latency: combinational.
// Backpressure: none.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/sd_sector_arbiter.sv
// Round-robin share of the SD reader's single-sector port; tags the byte stream with owner ID.
// Latency: ack 1 cycle after an IDLE grant; dout_* 1 cycle behind the reader; done 1 cycle after rdone.
// Backpressure: none on the byte stream; requesters hold req until ack, reader paces via rbusy/rdone.
module sd_sector_arbiter
    import sd_sector_arbiter_pkg::*;
#(
    parameter int          NREQ        = 4,
    parameter logic [23:0] WDOG_CYCLES = 24'd8_000_000,
    localparam int         IDW         = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   req_sector,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      done,
    sd_sector_arbiter_if.master  rd,
    output logic                 dout_valid,
    output logic [IDW-1:0]       dout_id,
    output byte_addr_t           dout_addr,
    output byte_t                dout_byte,
    output logic                 owner_busy,
    output logic [IDW-1:0]       owner_id,
    output logic                 stall
);

    arb_state_t      state, state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  pick_idx;
    logic [NREQ-1:0] pick_grant;
    logic            pick_any;
    logic            grant_ok;
    sector_t         rsector_q;
    sector_t         req_arr [NREQ];
    logic [23:0]     wdog_cnt;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_arr[i] = req_sector[32*i +: 32];
        end
    end

    rr_picker #(.N(NREQ), .IW(IDW)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // rdone is still accompanied by rbusy, so the earliest regrant is two cycles after it
    assign grant_ok      = (state == ARB_IDLE) && !rd.rbusy && !rd.rdone && pick_any;
    assign owner_busy    = (state != ARB_IDLE);
    assign rd.rstart     = (state == ARB_ISSUE) && !rd.rbusy;
    assign rd.rsector_no = rsector_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:     if (grant_ok)  state_nxt = ARB_ISSUE;
            ARB_ISSUE:    if (rd.rbusy)  state_nxt = ARB_WAITDONE;
            ARB_WAITDONE: if (rd.rdone)  state_nxt = ARB_IDLE;
            default:                     state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack       <= '0;
            done      <= '0;
            rsector_q <= '0;
            owner_id  <= '0;
            rr_ptr    <= IDW'(NREQ - 1);
            stall     <= 1'b0;
            wdog_cnt  <= '0;
        end else begin
            ack  <= '0;
            done <= '0;
            if (grant_ok) begin
                ack       <= pick_grant;
                rsector_q <= req_arr[pick_idx];
                owner_id  <= pick_idx;
                rr_ptr    <= pick_idx;
            end
            if (state == ARB_WAITDONE) begin
                if (rd.rdone) begin
                    done     <= NREQ'(1) << owner_id;
                    stall    <= 1'b0;
                    wdog_cnt <= '0;
                end else begin
                    // stall rises together with the count reaching the limit; reader keeps retrying
                    if (wdog_cnt != WDOG_CYCLES) wdog_cnt <= wdog_cnt + 24'd1;
                    if (wdog_cnt + 24'd1 == WDOG_CYCLES) stall <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid <= 1'b0;
            dout_id    <= '0;
            dout_addr  <= '0;
            dout_byte  <= '0;
        end else begin
            dout_valid <= rd.outreq && owner_busy;
            if (rd.outreq && owner_busy) begin
                dout_id   <= owner_id;
                dout_addr <= rd.outaddr;
                dout_byte <= rd.outbyte;
            end
        end
    end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed bench for sd_sector_arbiter with a behavioural SD reader and a byte-stream monitor.
module tb_sd_sector_arbiter;
    import sd_sector_arbiter_pkg::*;

    localparam int          NREQ = 4;
    localparam logic [23:0] WDOG = 24'd100;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*32-1:0] req_sector;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   done;
    logic              dout_valid;
    logic [1:0]        dout_id;
    byte_addr_t        dout_addr;
    byte_t             dout_byte;
    logic              owner_busy;
    logic [1:0]        owner_id;
    logic              stall;

    sd_sector_arbiter_if rd_if();

    sd_sector_arbiter #(.NREQ(NREQ), .WDOG_CYCLES(WDOG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_sector (req_sector),
        .ack        (ack),
        .done       (done),
        .rd         (rd_if),
        .dout_valid (dout_valid),
        .dout_id    (dout_id),
        .dout_addr  (dout_addr),
        .dout_byte  (dout_byte),
        .owner_busy (owner_busy),
        .owner_id   (owner_id),
        .stall      (stall)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reader model state
    logic        force_busy   = 1'b0;
    logic        stray_outreq = 1'b0;
    int          rm_phase     = 0;
    int          rm_hold      = 0;
    int          rm_hold_cnt  = 0;
    logic [8:0]  rm_addr      = '0;
    logic [31:0] rm_sector    = '0;
    int          rdone_cyc    = 0;

    // monitor state
    int          beats = 0, bad_beats = 0, rstart_hits = 0, rstart_overlap = 0;
    int          ack_cnt = 0, done_cnt = 0, done_cyc = 0;
    logic [3:0]  last_done = '0;
    logic [8:0]  mon_addr = '0;
    logic [1:0]  exp_id = '0;
    logic [31:0] exp_sector = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reader: sees rstart, raises rbusy a cycle later, streams 512 bytes, holds, then rdone.
    initial begin
        rd_if.rbusy = 1'b0; rd_if.rdone = 1'b0; rd_if.outreq = 1'b0;
        rd_if.outaddr = '0; rd_if.outbyte = '0;
        forever begin
            @(negedge clk);
            rd_if.rdone  = 1'b0;
            rd_if.outreq = 1'b0;
            if (!rst_n) begin
                rm_phase = 0;
                rd_if.rbusy = 1'b0;
            end else if (force_busy) begin
                rd_if.rbusy = 1'b1;
            end else begin
                case (rm_phase)
                    0: begin
                        rd_if.rbusy = 1'b0;
                        if (stray_outreq) begin
                            rd_if.outreq = 1'b1; rd_if.outaddr = 9'h055; rd_if.outbyte = 8'hAA;
                        end
                        if (rd_if.rstart) begin
                            rm_sector = rd_if.rsector_no;
                            rm_phase  = 1;
                        end
                    end
                    1: begin
                        rd_if.rbusy = 1'b1;
                        rm_addr  = '0;
                        rm_phase = 2;
                    end
                    2: begin
                        rd_if.outreq  = 1'b1;
                        rd_if.outaddr = rm_addr;
                        rd_if.outbyte = 8'(rm_sector[7:0] + rm_addr[7:0]);
                        if (rm_addr == 9'd511) begin
                            rm_phase = 3; rm_hold_cnt = 0;
                        end else begin
                            rm_addr = rm_addr + 9'd1;
                        end
                    end
                    default: begin
                        if (rm_hold_cnt >= rm_hold) begin
                            rd_if.rdone = 1'b1;
                            rdone_cyc = cyc;
                            rm_phase = 0;
                        end else begin
                            rm_hold_cnt++;
                        end
                    end
                endcase
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rd_if.rstart) begin
            rstart_hits++;
            if (rd_if.rbusy) rstart_overlap++;
        end
        if (ack != '0) ack_cnt++;
        if (done != '0) begin
            done_cnt++; done_cyc = cyc; last_done = done;
        end
        if (dout_valid) begin
            if (dout_addr != mon_addr || dout_id != exp_id ||
                dout_byte != 8'(exp_sector[7:0] + mon_addr[7:0])) bad_beats++;
            mon_addr = mon_addr + 9'd1;
            beats++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic busy);
        rst_n = 1'b0; req = '0; force_busy = busy; stray_outreq = 1'b0; rm_hold = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic begin_xfer(input logic [1:0] id, input logic [31:0] sect);
        exp_id = id; exp_sector = sect; beats = 0; bad_beats = 0; mon_addr = '0;
    endtask

    task automatic wait_ack(input int budget, output logic [3:0] got, output logic ok, output int at);
        ok = 1'b0; got = '0; at = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (ack != '0) begin
                ok = 1'b1; got = ack; at = cyc;
            end
        end
    endtask

    task automatic wait_done(input int budget, output logic ok);
        int start;
        start = done_cnt; ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (done_cnt != start) ok = 1'b1;
        end
    endtask

    task automatic finish_xfer(input string tag, input logic [3:0] exp_done);
        logic ok;
        wait_done(2000, ok);
        check_eq({tag, "_done_seen"}, 32'(ok), 32'd1);
        check_eq({tag, "_done"}, 32'(last_done), 32'(exp_done));
        check_eq({tag, "_beats"}, 32'(beats), 32'd512);
        check_eq({tag, "_bad_beats"}, 32'(bad_beats), 32'd0);
    endtask

    initial begin
        logic       ok;
        logic [3:0] got;
        int         at, a0, d0;
        int         exp_order [5] = '{0, 1, 2, 3, 0};
        rst_n = 1'b0; req = '0; req_sector = '0;

        // 1: single requester, plus stray outreq while idle
        do_reset(1'b0);
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_rstart", 32'(rd_if.rstart), 32'd0);
        check_eq("rst_rsector", rd_if.rsector_no, 32'd0);
        check_eq("rst_busy_id_stall", {29'd0, owner_busy, owner_id}, 32'd0);
        check_eq("rst_stall_dv", {30'd0, stall, dout_valid}, 32'd0);
        stray_outreq = 1'b1;
        repeat (4) tick();
        stray_outreq = 1'b0;
        tick();
        check_eq("t1_stray_beats", 32'(beats), 32'd0);
        rstart_hits = 0;
        req_sector[31:0] = 32'h10; req = 4'b0001;
        tick();
        check_eq("t1_ack", 32'(ack), 32'b0001);
        check_eq("t1_rsector", rd_if.rsector_no, 32'h10);
        check_eq("t1_owner", {30'd0, owner_busy, owner_id[0]}, 32'b10);
        check_eq("t1_rstart", 32'(rd_if.rstart), 32'd1);
        begin_xfer(2'd0, 32'h10); req = '0;
        finish_xfer("t1", 4'b0001);
        check_eq("t1_done_lat", 32'(done_cyc - rdone_cyc), 32'd1);
        check_eq("t1_rstart_cycles", 32'(rstart_hits), 32'd2);
        check_eq("t1_idle_after", 32'(owner_busy), 32'd0);

        // 2: all four requesting, round-robin order
        do_reset(1'b0);
        for (int s = 0; s < NREQ; s++) req_sector[32*s +: 32] = 32'h20 + 32'(s);
        rstart_overlap = 0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(50, got, ok, at);
            check_eq("t2_ack_seen", 32'(ok), 32'd1);
            check_eq("t2_ack", 32'(got), 32'(4'b0001 << exp_order[k]));
            check_eq("t2_rsector", rd_if.rsector_no, 32'h20 + 32'(exp_order[k]));
            check_eq("t2_outstanding", 32'(ack_cnt - done_cnt), 32'd1);
            if (k > 0) check_eq("t2_regrant_gap", 32'(at - rdone_cyc), 32'd2);
            begin_xfer(2'(exp_order[k]), 32'h20 + 32'(exp_order[k]));
            if (k == 4) req = '0;
            finish_xfer("t2", 4'(4'b0001 << exp_order[k]));
        end
        check_eq("t2_rstart_overlap", 32'(rstart_overlap), 32'd0);

        // 3: card never initialised, then released
        do_reset(1'b1);
        req_sector[63:32] = 32'h31; req = 4'b0010;
        a0 = ack_cnt; rstart_hits = 0;
        repeat (10000) tick();
        check_eq("t3_no_ack", 32'(ack_cnt - a0), 32'd0);
        check_eq("t3_no_rstart", 32'(rstart_hits), 32'd0);
        force_busy = 1'b0;
        tick();
        check_eq("t3_ack", 32'(ack), 32'b0010);
        begin_xfer(2'd1, 32'h31); req = '0;
        finish_xfer("t3", 4'b0010);

        // 4: watchdog
        do_reset(1'b0);
        rm_hold = 150;
        req_sector[95:64] = 32'h44; req = 4'b0100;
        tick();
        check_eq("t4_ack", 32'(ack), 32'b0100);
        begin_xfer(2'd2, 32'h44); req = '0;
        repeat (101) tick();
        check_eq("t4_stall_pre", 32'(stall), 32'd0);
        tick();
        check_eq("t4_stall_set", 32'(stall), 32'd1);
        repeat (498) tick();
        check_eq("t4_stall_sticky", 32'(stall), 32'd1);
        finish_xfer("t4", 4'b0100);
        check_eq("t4_stall_clear", 32'(stall), 32'd0);

        // 5: short pulse ignored; drop after ack still completes
        do_reset(1'b0);
        req_sector[31:0] = 32'h50; req_sector[95:64] = 32'h52; req = 4'b0001;
        tick();
        check_eq("t5_ack0", 32'(ack), 32'b0001);
        begin_xfer(2'd0, 32'h50); req = '0;
        repeat (20) tick();
        a0 = ack_cnt;
        req = 4'b0100;
        tick();
        req = '0;
        finish_xfer("t5a", 4'b0001);
        repeat (20) tick();
        check_eq("t5_pulse_ignored", 32'(ack_cnt - a0), 32'd0);
        req = 4'b0100;
        tick();
        check_eq("t5_ack2", 32'(ack), 32'b0100);
        begin_xfer(2'd2, 32'h52);
        repeat (3) tick();
        req = '0;
        finish_xfer("t5b", 4'b0100);

        // 6: async reset mid-transfer
        do_reset(1'b0);
        req_sector[31:0] = 32'h60; req = 4'b0001;
        tick();
        check_eq("t6_ack0", 32'(ack), 32'b0001);
        begin_xfer(2'd0, 32'h60); req = '0;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            tick();
            if (beats >= 200) ok = 1'b1;
        end
        check_eq("t6_reach_byte200", 32'(ok), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_ctrl", {26'd0, owner_busy, rd_if.rstart, stall, dout_valid, owner_id}, 32'd0);
        check_eq("t6_rst_ackdone", {24'd0, ack, done}, 32'd0);
        check_eq("t6_rst_rsector", rd_if.rsector_no, 32'd0);
        check_eq("t6_rst_dout", {13'd0, dout_id, dout_addr, dout_byte}, 32'd0);
        d0 = done_cnt; a0 = beats;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check_eq("t6_no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("t6_no_beats", 32'(beats - a0), 32'd0);
        req_sector[95:64] = 32'h66; req = 4'b0100;
        tick();
        check_eq("t6_ack2", 32'(ack), 32'b0100);
        check_eq("t6_rsector", rd_if.rsector_no, 32'h66);
        begin_xfer(2'd2, 32'h66); req = '0;
        finish_xfer("t6", 4'b0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
